weight_feeder: RTL and testbench

//   Drives the weight-stream input at the top of one systolic PE column.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/weight_feeder.sv | 122 ++++++++++++
 tb/tb_weight_feeder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: beat field positions used by both PEs and feeders,
// plus the weight feeder state encoding.
package tpu_pkg;

    localparam int W_VALID_BIT = 0;
    localparam int W_SEL_BIT   = 1;
    localparam int W_DATA_LSB  = 2;

    typedef enum logic {
        FEED_LOAD = 1'b0,
        FEED_FULL = 1'b1
    } feed_state_e;

endpackage

// File: rtl/weight_feeder.sv
// Weight feeder for one systolic PE column: loads ROWS weights into the shadow
// bank, then holds until the controller swaps banks.
module weight_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int TILE_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic                    flush_i,
    input  logic                    swap_i,
    output logic [DATA_WIDTH+1:0]   weight_out,
    output logic                    shadow_full_o,
    output logic                    active_bank_o,
    output logic [TILE_CNT_W-1:0]   tiles_o,
    output logic                    err_o
);

    localparam int CNT_W = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS - 1);

    feed_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    bank_q, bank_d;
    logic [TILE_CNT_W-1:0]   tiles_q, tiles_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH+1:0]   weight_q, weight_d;
    logic                    accept_s;

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FEED_LOAD;
            cnt_q    <= {CNT_W{1'b0}};
            bank_q   <= 1'b0;
            tiles_q  <= {TILE_CNT_W{1'b0}};
            err_q    <= 1'b0;
            weight_q <= {(DATA_WIDTH+2){1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            tiles_q  <= tiles_d;
            err_q    <= err_d;
            weight_q <= weight_d;
        end
    end

    // Next-state logic; a swap during LOAD is dropped and only flagged
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        tiles_d = tiles_q;
        err_d   = err_q;
        case (state_q)
            FEED_LOAD: begin
                if (swap_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (flush_i) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (accept_s) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = FEED_FULL;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FEED_FULL: begin
                if (swap_i) begin
                    bank_d  = ~bank_q;
                    tiles_d = tiles_q + {{(TILE_CNT_W-1){1'b0}}, 1'b1};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = FEED_LOAD;
                end else begin
                    state_d = FEED_FULL;
                end
            end
            default: begin
                state_d = FEED_LOAD;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Beat assembly; idle beats carry the post-swap sel so PEs see the flip at once
    always_comb begin
        weight_d = {(DATA_WIDTH+2){1'b0}};
        weight_d[W_VALID_BIT] = accept_s;
        weight_d[W_SEL_BIT]   = bank_d;
        if (accept_s) begin
            weight_d[DATA_WIDTH+1:W_DATA_LSB] = w_data_i;
        end else begin
            weight_d[DATA_WIDTH+1:W_DATA_LSB] = {DATA_WIDTH{1'b0}};
        end
    end

    // Handshake and status outputs derived from state
    always_comb begin
        w_ready_o     = (state_q == FEED_LOAD) && !flush_i;
        shadow_full_o = (state_q == FEED_FULL);
    end

    assign accept_s      = w_valid_i && w_ready_o;
    assign weight_out    = weight_q;
    assign active_bank_o = bank_q;
    assign tiles_o       = tiles_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_weight_feeder.sv
// Self-checking bench for weight_feeder: directed vector table, hand-written
// flush/reset sequences and a randomized run against a behavioural model.
module tb_weight_feeder;

    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int TW   = 16;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [DW-1:0]   w_data_i = '0;
    logic            w_valid_i = 1'b0;
    logic            w_ready_o;
    logic            flush_i = 1'b0;
    logic            swap_i = 1'b0;
    logic [DW+1:0]   weight_out;
    logic            shadow_full_o;
    logic            active_bank_o;
    logic [TW-1:0]   tiles_o;
    logic            err_o;

    int checks   = 0;
    int failures = 0;

    weight_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .TILE_CNT_W(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .w_data_i(w_data_i), .w_valid_i(w_valid_i),
        .w_ready_o(w_ready_o), .flush_i(flush_i), .swap_i(swap_i),
        .weight_out(weight_out), .shadow_full_o(shadow_full_o),
        .active_bank_o(active_bank_o), .tiles_o(tiles_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: counts loaded weights, tracks bank/tiles/error
    int   m_loaded;
    bit   m_full;
    bit   m_bank;
    int   m_tiles;
    bit   m_err;
    logic [DW+1:0] m_w;

    task automatic model_apply(input bit r, input bit v, input logic [DW-1:0] d,
                               input bit f, input bit s);
        bit take;
        if (r) begin
            m_loaded = 0; m_full = 0; m_bank = 0; m_tiles = 0; m_err = 0; m_w = '0;
        end else begin
            take = v && !m_full && !f;
            if (!m_full && s) m_err = 1;
            if (m_full && s) begin
                m_bank  = !m_bank;
                m_tiles = (m_tiles + 1) % (1 << TW);
                m_full  = 0;
                m_loaded = 0;
            end else if (!m_full && f) begin
                m_loaded = 0;
            end else if (take) begin
                m_loaded++;
                if (m_loaded == ROWS) begin
                    m_full = 1;
                    m_loaded = 0;
                end
            end
            m_w = take ? {d, m_bank, 1'b1} : {{DW{1'b0}}, m_bank, 1'b0};
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                        input bit f, input bit s);
        @(negedge clk_i);
        rst_i = r; w_valid_i = v; w_data_i = d; flush_i = f; swap_i = s;
        #1;
        if (!r) chk("ready", 32'(w_ready_o), 32'(!m_full && !f));
        model_apply(r, v, d, f, s);
        @(posedge clk_i);
        #1;
        chk("weight_out", 32'(weight_out), 32'(m_w));
        chk("shadow_full", 32'(shadow_full_o), 32'(m_full));
        chk("active_bank", 32'(active_bank_o), 32'(m_bank));
        chk("tiles", 32'(tiles_o), 32'(m_tiles));
        chk("err", 32'(err_o), 32'(m_err));
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          f;
        logic          s;
        logic          e_ready;
        logic [DW+1:0] e_w;
        logic          e_full;
        logic          e_bank;
        logic [TW-1:0] e_tiles;
        logic          e_err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // v, d, f, s | ready, weight_out, full, bank, tiles, err
        tbl[0]  = '{1'b1, 8'd1,  1'b0, 1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 10'd9,  1'b0, 1'b0, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'd3,  1'b0, 1'b0, 1'b1, 10'd13, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'd4,  1'b0, 1'b0, 1'b1, 10'd17, 1'b1, 1'b0, 16'd0, 1'b0};
        tbl[4]  = '{1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 10'd2,  1'b0, 1'b1, 16'd1, 1'b0};
        tbl[6]  = '{1'b1, 8'd7,  1'b0, 1'b0, 1'b1, 10'd31, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[7]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 10'd2,  1'b0, 1'b1, 16'd1, 1'b0};
        tbl[8]  = '{1'b1, 8'd8,  1'b0, 1'b1, 1'b1, 10'd35, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[9]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 10'd2,  1'b0, 1'b1, 16'd1, 1'b1};
        tbl[10] = '{1'b1, 8'd9,  1'b0, 1'b0, 1'b1, 10'd39, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[11] = '{1'b1, 8'd10, 1'b0, 1'b1, 1'b1, 10'd43, 1'b1, 1'b1, 16'd1, 1'b1};
        tbl[12] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 10'd2,  1'b1, 1'b1, 16'd1, 1'b1};
        tbl[13] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 16'd2, 1'b1};
        tbl[14] = '{1'b1, 8'd11, 1'b1, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 16'd2, 1'b1};

        // Power-up reset and reset-state checks
        rst_i = 1'b1;
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rst_weight_out", 32'(weight_out), 32'd0);
        chk("rst_full", 32'(shadow_full_o), 32'd0);
        chk("rst_bank", 32'(active_bank_o), 32'd0);
        chk("rst_tiles", 32'(tiles_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed table: load, swap, toggling valid, LOAD swaps, swap+flush, flush
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            w_valid_i = tbl[i].v; w_data_i = tbl[i].d;
            flush_i = tbl[i].f; swap_i = tbl[i].s;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(w_ready_o), 32'(tbl[i].e_ready));
            @(posedge clk_i);
            #1;
            chk($sformatf("tbl%0d_w", i), 32'(weight_out), 32'(tbl[i].e_w));
            chk($sformatf("tbl%0d_full", i), 32'(shadow_full_o), 32'(tbl[i].e_full));
            chk($sformatf("tbl%0d_bank", i), 32'(active_bank_o), 32'(tbl[i].e_bank));
            chk($sformatf("tbl%0d_tiles", i), 32'(tiles_o), 32'(tbl[i].e_tiles));
            chk($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].e_err));
        end

        // Flush after two accepts: four more weights needed before FULL
        step(1, 0, 8'd0, 0, 0);
        step(0, 1, 8'h21, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h23, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
        chk("flush_not_full", 32'(shadow_full_o), 32'd0);
        step(0, 1, 8'h33, 0, 0);
        chk("flush_full", 32'(shadow_full_o), 32'd1);
        chk("flush_bank", 32'(active_bank_o), 32'd0);

        // Reset mid-load with bank=1: full reload required afterwards
        step(0, 0, 8'd0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        step(1, 1, 8'h44, 0, 0);
        chk("rst_mid_bank", 32'(active_bank_o), 32'd0);
        chk("rst_mid_w", 32'(weight_out), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h50 + i), 0, 0);
        chk("rst_reload_not_full", 32'(shadow_full_o), 32'd0);
        step(0, 1, 8'h53, 0, 0);
        chk("rst_reload_full", 32'(shadow_full_o), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
